// File: rtl/count_mode_sequencer.sv
// Sequences an external up/down counter through a latched mode pattern and checks its count.
// Optional macro CNTSEQ_LOOP_EN: the pattern repeats until stop instead of ending after L steps.
module count_mode_sequencer #(
  parameter int PAT_W = 20,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] pattern,
  input  logic [4:0]       len,
  input  logic [CNT_W-1:0] count,
  output logic             mode,
  output logic             cnt_reset,
  output logic             busy,
  output logic             done,
  output logic [4:0]       step_idx,
  output logic             mismatch
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [4:0]       last_q, last_d;
  logic [4:0]       step_q, step_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic             mode_q, mode_d;
  logic             cnt_reset_q, cnt_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [4:0]       eff_last;
  logic [4:0]       next_idx;

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    last_d      = last_q;
    step_d      = step_q;
    exp_d       = exp_q;
    mode_d      = mode_q;
    cnt_reset_d = cnt_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    mismatch_d  = mismatch_q;
    next_idx    = step_q + 5'd1;
    // A zero or oversized length means the full pattern width.
    eff_last    = (len == 5'd0 || int'(len) > PAT_W) ? 5'(PAT_W - 1) : len - 5'd1;

    case (state_q)
      IDLE: begin
        cnt_reset_d = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        mode_d      = 1'b0;
        step_d      = 5'd0;
        if (start) begin
          state_d     = RUN;
          pat_d       = pattern;
          last_d      = eff_last;
          mode_d      = pattern[0];
          cnt_reset_d = 1'b0;
          busy_d      = 1'b1;
          exp_d       = '0;
          mismatch_d  = 1'b0;
        end
      end
      RUN: begin
        exp_d      = mode_q ? exp_q + CNT_W'(1) : exp_q - CNT_W'(1);
        mismatch_d = mismatch_q | (count != exp_q);
        if (stop) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (step_q == last_q) begin
`ifdef CNTSEQ_LOOP_EN
          step_d = 5'd0;
          mode_d = pat_q[0];
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end else begin
          step_d = next_idx;
          mode_d = pat_q[next_idx];
        end
      end
      DONE: begin
        mismatch_d  = mismatch_q | (count != exp_q);
        state_d     = IDLE;
        cnt_reset_d = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        mode_d      = 1'b0;
        step_d      = 5'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      last_q      <= '0;
      step_q      <= '0;
      exp_q       <= '0;
      mode_q      <= 1'b0;
      cnt_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      last_q      <= last_d;
      step_q      <= step_d;
      exp_q       <= exp_d;
      mode_q      <= mode_d;
      cnt_reset_q <= cnt_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign mode      = mode_q;
  assign cnt_reset = cnt_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step_idx  = step_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_count_mode_sequencer.sv
// Scoreboard bench for count_mode_sequencer with a 3-bit up/down counter model on the feedback path.
// Scenarios that rely on runs ending by themselves are skipped when CNTSEQ_LOOP_EN is defined.
module tb_count_mode_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mode;
    logic       cnt_rst;
    logic       mism;
    logic [4:0] step;
    logic [2:0] cnt;
  } obs_t;

  localparam obs_t IDLE_OBS = '{busy: 1'b0, done: 1'b0, mode: 1'b0, cnt_rst: 1'b1,
                                mism: 1'b0, step: 5'd0, cnt: 3'd0};

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [19:0] pattern;
  logic [4:0]  len;
  logic [2:0]  count;
  logic        mode;
  logic        cnt_reset;
  logic        busy;
  logic        done;
  logic [4:0]  step_idx;
  logic        mismatch;

  logic [2:0]  cnt_r;
  logic        force_en;
  logic [2:0]  force_val;

  int   checks;
  int   passes;
  obs_t exp_q[$];
  obs_t e;
  obs_t o;

  count_mode_sequencer #(.PAT_W(20), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pattern(pattern),
    .len(len), .count(count), .mode(mode), .cnt_reset(cnt_reset), .busy(busy),
    .done(done), .step_idx(step_idx), .mismatch(mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached up/down counter, with an override used to inject a wrong count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_r <= 3'd0;
    else if (cnt_reset) cnt_r <= 3'd0;
    else cnt_r <= mode ? cnt_r + 3'd1 : cnt_r - 3'd1;
  end
  assign count = force_en ? force_val : cnt_r;

  function automatic obs_t sample_obs();
    return {busy, done, mode, cnt_reset, mismatch, step_idx, count};
  endfunction

  // Expected per-cycle trace of one run, from the cycle after the start edge to two idle cycles.
  task automatic push_run(input logic [19:0] pat, input int len_in, input int stop_at,
                          input int force_at, input logic [2:0] fval);
    int l_eff, step, k;
    logic [2:0] cnt, shown;
    logic m, mism;
    l_eff = (len_in == 0 || len_in > 20) ? 20 : len_in;
    step = 0; k = 0; cnt = 3'd0; mism = 1'b0; m = 1'b0;
    while (1) begin
      m = pat[step];
      shown = (k == force_at) ? fval : cnt;
      exp_q.push_back({1'b1, 1'b0, m, 1'b0, mism, 5'(step), shown});
      if (shown != cnt) mism = 1'b1;
      cnt = m ? cnt + 3'd1 : cnt - 3'd1;
      if (k == stop_at || step == l_eff - 1) break;
      step++; k++;
    end
    exp_q.push_back({1'b1, 1'b1, m, 1'b0, mism, 5'(step), cnt});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, mism, 5'd0, (m ? cnt + 3'd1 : cnt - 3'd1)});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, mism, 5'd0, 3'd0});
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    start = 1'b1;
    for (int i = 0; i < 2; i++) exp_q.push_back(IDLE_OBS);
    @(negedge clk);
    e = exp_q.pop_front(); o = sample_obs(); checks++;
    if (o !== e) $display("[TB] FAIL reset_hold: got %h required %h", o, e); else passes++;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front(); o = sample_obs(); checks++;
    if (o !== e) $display("[TB] FAIL reset_release: got %h required %h", o, e); else passes++;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(IDLE_OBS);
      @(negedge clk);
      e = exp_q.pop_front(); o = sample_obs(); checks++;
      if (o !== e) $display("[TB] FAIL idle_no_start c%0d: got %h required %h", i, o, e);
      else passes++;
    end
  endtask

  task automatic test_long_pattern();
    int k, done_k;
    push_run(20'h003FF, 20, -1, -1, 3'd0);
    @(negedge clk); pattern = 20'h003FF; len = 5'd20; start = 1'b1;
    k = 0; done_k = -1;
    while (exp_q.size() > 0) begin
      if (k >= 64) begin
        $display("[TB] FAIL long_timeout: %0d entries left, required 0", exp_q.size());
        checks++; exp_q.delete(); break;
      end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; force_en = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front(); o = sample_obs(); checks++;
      if (o !== e) $display("[TB] FAIL long c%0d: got %h required %h", k, o, e); else passes++;
      if (o.done) done_k = k;
      k++;
    end
    checks++;
    if (done_k !== 20) $display("[TB] FAIL long_done_cycle: got %0d required 20", done_k);
    else passes++;
  endtask

  task automatic test_short_pattern();
    int k, busy_cycles, done_pulses;
    push_run(20'h00005, 3, -1, -1, 3'd0);
    @(negedge clk); pattern = 20'h00005; len = 5'd3; start = 1'b1;
    k = 0; busy_cycles = 0; done_pulses = 0;
    while (exp_q.size() > 0) begin
      if (k >= 64) begin
        $display("[TB] FAIL short_timeout: %0d entries left, required 0", exp_q.size());
        checks++; exp_q.delete(); break;
      end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; force_en = 1'b0;
      // A start with a different pattern mid-run must not disturb the latched one.
      if (k == 1) begin start = 1'b1; pattern = 20'hFFFFA; end
      @(negedge clk);
      e = exp_q.pop_front(); o = sample_obs(); checks++;
      if (o !== e) $display("[TB] FAIL short c%0d: got %h required %h", k, o, e); else passes++;
      busy_cycles += int'(o.busy);
      done_pulses += int'(o.done);
      k++;
    end
    checks++;
    if (busy_cycles !== 4) $display("[TB] FAIL short_busy_len: got %0d required 4", busy_cycles);
    else passes++;
    checks++;
    if (done_pulses !== 1) $display("[TB] FAIL short_done_pulses: got %0d required 1", done_pulses);
    else passes++;
  endtask

  task automatic test_len_boundary();
    int lens[3] = '{0, 25, 1};
    int k;
    logic [19:0] p;
    for (int r = 0; r < 3; r++) begin
      p = 20'($urandom);
      push_run(p, lens[r], -1, -1, 3'd0);
      @(negedge clk); pattern = p; len = 5'(lens[r]); start = 1'b1;
      k = 0;
      while (exp_q.size() > 0) begin
        if (k >= 64) begin
          $display("[TB] FAIL len%0d_timeout: %0d entries left, required 0", lens[r], exp_q.size());
          checks++; exp_q.delete(); break;
        end
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; force_en = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front(); o = sample_obs(); checks++;
        if (o !== e) $display("[TB] FAIL len%0d c%0d: got %h required %h", lens[r], k, o, e);
        else passes++;
        k++;
      end
    end
  endtask

  task automatic test_stop();
    int k;
    push_run(20'hFFFFF, 20, 4, -1, 3'd0);
    // stop raised together with start: start wins in IDLE.
    @(negedge clk); pattern = 20'hFFFFF; len = 5'd20; start = 1'b1; stop = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      if (k >= 64) begin
        $display("[TB] FAIL stop_timeout: %0d entries left, required 0", exp_q.size());
        checks++; exp_q.delete(); break;
      end
      @(posedge clk); #1;
      start = 1'b0; stop = (k == 4); force_en = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front(); o = sample_obs(); checks++;
      if (o !== e) $display("[TB] FAIL stop c%0d: got %h required %h", k, o, e); else passes++;
      k++;
    end
    stop = 1'b0;
  endtask

  task automatic test_mismatch();
    int k, f_at;
    for (int r = 0; r < 2; r++) begin
      f_at = (r == 0) ? 2 : -1;
      push_run(20'hFFFFF, 6, -1, f_at, 3'd5);
      @(negedge clk); pattern = 20'hFFFFF; len = 5'd6; start = 1'b1;
      k = 0;
      while (exp_q.size() > 0) begin
        if (k >= 64) begin
          $display("[TB] FAIL mism_timeout: %0d entries left, required 0", exp_q.size());
          checks++; exp_q.delete(); break;
        end
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; force_en = (k == f_at); force_val = 3'd5;
        @(negedge clk);
        e = exp_q.pop_front(); o = sample_obs(); checks++;
        if (o !== e) $display("[TB] FAIL mism r%0d c%0d: got %h required %h", r, k, o, e);
        else passes++;
        k++;
      end
      force_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); pattern = 20'hFFFFF; len = 5'd20; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (step_idx !== 5'd7) $display("[TB] FAIL pre_reset_step: got %0d required 7", step_idx);
    else passes++;
    reset = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(IDLE_OBS);
    #1;
    e = exp_q.pop_front(); o = sample_obs(); checks++;
    if (o !== e) $display("[TB] FAIL reset_immediate: got %h required %h", o, e); else passes++;
    @(negedge clk);
    e = exp_q.pop_front(); o = sample_obs(); checks++;
    if (o !== e) $display("[TB] FAIL reset_start_ignored: got %h required %h", o, e); else passes++;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front(); o = sample_obs(); checks++;
    if (o !== e) $display("[TB] FAIL reset_after: got %h required %h", o, e); else passes++;
  endtask

`ifdef CNTSEQ_LOOP_EN
  task automatic test_loop();
    int k;
    for (int i = 0; i < 8; i++)
      exp_q.push_back({1'b1, 1'b0, (i % 2 == 0), 1'b0, 1'b0, 5'(i % 2), 3'(i % 2)});
    exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 3'd0});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd7});
    exp_q.push_back(IDLE_OBS);
    @(negedge clk); pattern = 20'h00001; len = 5'd2; start = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      if (k >= 64) begin
        $display("[TB] FAIL loop_timeout: %0d entries left, required 0", exp_q.size());
        checks++; exp_q.delete(); break;
      end
      @(posedge clk); #1;
      start = 1'b0; stop = (k == 7); force_en = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front(); o = sample_obs(); checks++;
      if (o !== e) $display("[TB] FAIL loop c%0d: got %h required %h", k, o, e); else passes++;
      k++;
    end
    stop = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; passes = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pattern = '0; len = '0;
    force_en = 1'b0; force_val = 3'd0;
    $display("[TB] count_mode_sequencer bench starting");
    test_reset();
`ifndef CNTSEQ_LOOP_EN
    test_long_pattern();
    test_short_pattern();
    test_len_boundary();
    test_mismatch();
`endif
    test_stop();
    test_reset_mid_run();
`ifdef CNTSEQ_LOOP_EN
    test_loop();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
